// File: rtl/axi_wr_dispatch_pkg.sv
// axi_wr_dispatch_pkg
//   Shared types and constants for the AXI write dispatcher:
//   - state_t       : one-hot FSM state encoding
//   - BRESP_*       : AXI write response codes
//   - CLR_SEL       : window select value of the soft-clear window
//   - win_dec_t     : result of decoding an address window
//   - decode_window : maps a window select to clear / FIFO / last-field / error
package axi_wr_dispatch_pkg;

  typedef enum logic [3:0] {
    ST_INIT = 4'b0001,
    ST_IDLE = 4'b0010,
    ST_DATA = 4'b0100,
    ST_RESP = 4'b1000
  } state_t;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  localparam int unsigned CLR_SEL = 0;

  typedef struct packed {
    logic       err;
    logic       is_clr;
    logic       is_last;
    logic [2:0] fifo;
  } win_dec_t;

  // Windows: 0 = clear, 1+2f = FIFO f normal, 2+2f = FIFO f last-field.
  // Odd selects are normal fields, even non-zero selects are last fields.
  function automatic win_dec_t decode_window(input logic [31:0] sel, input int num_fifo);
    win_dec_t d;
    d = '0;
    if (sel == CLR_SEL) begin
      d.is_clr = 1'b1;
    end else if (sel <= 32'(2 * num_fifo)) begin
      d.fifo    = 3'((sel - 32'd1) >> 1);
      d.is_last = ~sel[0];
    end else begin
      d.err = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_wr_dispatch_index_ctr.sv
// dispatch_index_ctr
//   Wrapping field-index counter for one downstream FIFO.
//   clk     : clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear, wins over inc
//   inc     : synchronous increment, wraps 2^INDEX_W-1 -> 0
//   count   : current index
module dispatch_index_ctr #(
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [INDEX_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(INDEX_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/axi_wr_dispatch.sv
// axi_wr_dispatch
//   AXI4 write slave that decodes each burst by address window and streams
//   its beats into one of NUM_FIFO downstream FIFOs.
//   clk, reset_n        : clock, asynchronous active-low reset
//   axs_s0_aw*          : AW channel (awburst and low address bits ignored)
//   axs_s0_w*           : W channel, stalls while the target FIFO is full
//   axs_s0_b*           : B channel, OKAY or SLVERR with echoed id
//   fifo_full           : per-FIFO full flags
//   fifo_clr            : per-FIFO clear pulses (INIT and clear window)
//   fifo_push           : per-FIFO push strobes
//   push_data/strb/index/last : shared push payload
module axi_wr_dispatch
  import axi_wr_dispatch_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int ID_W     = 4,
  parameter int NUM_FIFO = 2,
  parameter int INDEX_W  = 10,
  parameter int SEL_LSB  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ID_W-1:0]     axs_s0_awid,
  input  logic [ADDR_W-1:0]   axs_s0_awaddr,
  input  logic [7:0]          axs_s0_awlen,
  input  logic [2:0]          axs_s0_awsize,
  input  logic [1:0]          axs_s0_awburst,
  input  logic                axs_s0_awvalid,
  output logic                axs_s0_awready,
  input  logic [DATA_W-1:0]   axs_s0_wdata,
  input  logic [DATA_W/8-1:0] axs_s0_wstrb,
  input  logic                axs_s0_wlast,
  input  logic                axs_s0_wvalid,
  output logic                axs_s0_wready,
  output logic [ID_W-1:0]     axs_s0_bid,
  output logic [1:0]          axs_s0_bresp,
  output logic                axs_s0_bvalid,
  input  logic                axs_s0_bready,
  input  logic [NUM_FIFO-1:0] fifo_full,
  output logic [NUM_FIFO-1:0] fifo_clr,
  output logic [NUM_FIFO-1:0] fifo_push,
  output logic [DATA_W-1:0]   push_data,
  output logic [DATA_W/8-1:0] push_strb,
  output logic [INDEX_W-1:0]  push_index,
  output logic                push_last
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam int         FW        = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam logic [2:0] SIZE_FULL = 3'($clog2(STRB_W));

  state_t              state;
  logic                awready_q;
  logic                bvalid_q;
  logic [ID_W-1:0]     bid_q;
  logic [1:0]          bresp_q;
  logic [NUM_FIFO-1:0] fifo_clr_q;
  logic [FW-1:0]       f_q;
  logic                is_last_q;
  logic                is_clr_q;
  logic                err_q;
  logic                wlast_err_q;
  logic [7:0]          beat_cnt_q;

  win_dec_t            aw_dec;
  logic                aw_hs;
  logic                in_data;
  logic                w_hs;
  logic                data_hs;
  logic                clr_beat;
  logic                final_beat;
  logic [NUM_FIFO-1:0] clr_mask;
  logic [NUM_FIFO-1:0] ctr_clr;
  logic [NUM_FIFO-1:0] ctr_inc;
  logic [INDEX_W-1:0]  index [NUM_FIFO];
  logic                unused_ok;

  assign aw_dec = decode_window(32'(axs_s0_awaddr[ADDR_W-1:SEL_LSB]), NUM_FIFO);
  assign unused_ok = ^{axs_s0_awburst, axs_s0_awaddr[SEL_LSB-1:0], aw_dec.fifo};

  assign aw_hs      = (state == ST_IDLE) && awready_q && axs_s0_awvalid;
  assign in_data    = (state == ST_DATA);
  // Error and clear bursts never touch a FIFO, so they ignore its full flag.
  assign axs_s0_wready = in_data && (err_q || is_clr_q || !fifo_full[f_q]);
  assign w_hs       = axs_s0_wready && axs_s0_wvalid;
  assign final_beat = (beat_cnt_q == 8'd0);
  assign data_hs    = w_hs && !err_q && !is_clr_q;
  assign clr_beat   = w_hs && is_clr_q && !err_q;
  assign clr_mask   = clr_beat ? axs_s0_wdata[NUM_FIFO-1:0] : '0;
  // Counters clear on the handshake edge so the zeroed index lines up with
  // the registered fifo_clr pulse.
  assign ctr_clr    = (state == ST_INIT) ? '1 : clr_mask;

  always_comb begin
    fifo_push = '0;
    ctr_inc   = '0;
    if (data_hs) begin
      fifo_push[f_q] = 1'b1;
      ctr_inc[f_q]   = is_last_q && final_beat;
    end
  end

  assign push_data  = in_data ? axs_s0_wdata : '0;
  assign push_strb  = in_data ? axs_s0_wstrb : '0;
  assign push_index = in_data ? index[f_q] : '0;
  assign push_last  = data_hs && is_last_q && final_beat;

  assign axs_s0_awready = awready_q;
  assign axs_s0_bvalid  = bvalid_q;
  assign axs_s0_bid     = bid_q;
  assign axs_s0_bresp   = bresp_q;
  assign fifo_clr       = fifo_clr_q;

  for (genvar g = 0; g < NUM_FIFO; g++) begin : g_idx
    dispatch_index_ctr #(.INDEX_W(INDEX_W)) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (ctr_clr[g]),
      .inc     (ctr_inc[g]),
      .count   (index[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= BRESP_OKAY;
      fifo_clr_q  <= '0;
      f_q         <= '0;
      is_last_q   <= 1'b0;
      is_clr_q    <= 1'b0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          fifo_clr_q <= '1;
          awready_q  <= 1'b0;
          bvalid_q   <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_IDLE: begin
          fifo_clr_q <= '0;
          if (aw_hs) begin
            awready_q   <= 1'b0;
            bid_q       <= axs_s0_awid;
            f_q         <= aw_dec.fifo[FW-1:0];
            is_last_q   <= aw_dec.is_last;
            is_clr_q    <= aw_dec.is_clr;
            err_q       <= aw_dec.err || (axs_s0_awsize != SIZE_FULL);
            wlast_err_q <= 1'b0;
            beat_cnt_q  <= axs_s0_awlen;
            state       <= ST_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        ST_DATA: begin
          fifo_clr_q <= clr_mask;
          if (w_hs) begin
            if (final_beat) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || wlast_err_q || !axs_s0_wlast) ? BRESP_SLVERR : BRESP_OKAY;
              state    <= ST_RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
              if (axs_s0_wlast) wlast_err_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          fifo_clr_q <= '0;
          if (axs_s0_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          awready_q  <= 1'b0;
          bvalid_q   <= 1'b0;
          fifo_clr_q <= '0;
          state      <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_dispatch.sv
module tb_axi_wr_dispatch;

  logic        clk;
  logic        reset_n;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  fifo_full;
  logic [1:0]  fifo_clr;
  logic [1:0]  fifo_push;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  logic [9:0]  push_index;
  logic        push_last;

  int total = 0;
  int bad   = 0;
  int npush = 0;
  int clr_cycles = 0;
  logic [1:0] clr_or = '0;

  typedef struct {
    int          f;
    logic [31:0] data;
    logic [9:0]  idx;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] mon_push;
  logic [9:0] idx_model [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_wr_dispatch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .axs_s0_awid    (awid),
    .axs_s0_awaddr  (awaddr),
    .axs_s0_awlen   (awlen),
    .axs_s0_awsize  (awsize),
    .axs_s0_awburst (awburst),
    .axs_s0_awvalid (awvalid),
    .axs_s0_awready (awready),
    .axs_s0_wdata   (wdata),
    .axs_s0_wstrb   (wstrb),
    .axs_s0_wlast   (wlast),
    .axs_s0_wvalid  (wvalid),
    .axs_s0_wready  (wready),
    .axs_s0_bid     (bid),
    .axs_s0_bresp   (bresp),
    .axs_s0_bvalid  (bvalid),
    .axs_s0_bready  (bready),
    .fifo_full      (fifo_full),
    .fifo_clr       (fifo_clr),
    .fifo_push      (fifo_push),
    .push_data      (push_data),
    .push_strb      (push_strb),
    .push_index     (push_index),
    .push_last      (push_last)
  );

  // Push monitor: every push is checked against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_clr != 2'b00) begin
        clr_cycles++;
        clr_or = clr_or | fifo_clr;
      end
      if (fifo_push != 2'b00) begin
        npush++;
        total++;
        if ((fifo_push & fifo_full) != 2'b00) begin
          bad++;
          $display("FAIL push_into_full push=%b full=%b", fifo_push, fifo_full);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_push push=%b data=%h idx=%0d", fifo_push, push_data, push_index);
        end else begin
          mon_e = exp_q.pop_front();
          mon_push = 2'b01 << mon_e.f;
          if ({fifo_push, push_data, push_strb, push_index, push_last} !==
              {mon_push, mon_e.data, 4'hF, mon_e.idx, mon_e.last}) begin
            bad++;
            $display("FAIL push_payload got push=%b data=%h strb=%h idx=%0d last=%b want push=%b data=%h strb=f idx=%0d last=%b",
                     fifo_push, push_data, push_strb, push_index, push_last,
                     mon_push, mon_e.data, mon_e.idx, mon_e.last);
          end
        end
      end
    end
  end

  task automatic exp_burst(input int f, input int nb, input logic [31:0] base, input bit last);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      e.f    = f;
      e.data = base + 32'(b);
      e.idx  = idx_model[f];
      e.last = last && (b == nb - 1);
      exp_q.push_back(e);
    end
    if (last) idx_model[f] = idx_model[f] + 10'd1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (awready) ok = 1;
      @(posedge clk);
      #1;
    end
    awvalid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL aw_timeout addr=%h awready never seen", addr);
    end
  endtask

  task automatic send_burst(input int nbeats, input logic [31:0] base, input int early,
                            input int ff_from, input int ff_to, input bit chk, output int cyc);
    int beat;
    bit acc;
    beat = 0;
    cyc = 0;
    while (beat < nbeats && cyc < 200) begin
      cyc++;
      fifo_full[0] = (cyc >= ff_from && cyc <= ff_to);
      wvalid = 1'b1;
      wdata  = base + 32'(beat);
      wstrb  = 4'hF;
      wlast  = (early < 0) ? (beat == nbeats - 1) : (beat == early);
      @(negedge clk);
      acc = wready;
      if (chk) begin
        total++;
        if (wready !== !fifo_full[0]) begin
          bad++;
          $display("FAIL wready cyc=%0d got=%b want=%b", cyc, wready, !fifo_full[0]);
        end
      end
      @(posedge clk);
      #1;
      if (acc) beat++;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    fifo_full = 2'b00;
    if (beat < nbeats) begin
      total++; bad++;
      $display("FAIL w_timeout beats=%0d want=%0d", beat, nbeats);
    end
  endtask

  task automatic wait_b(output logic [3:0] id, output logic [1:0] resp, output int n);
    bit got;
    got = 0;
    n = 0;
    id = 4'h0;
    resp = 2'b11;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (bvalid) begin
        got = 1;
        id = bid;
        resp = bresp;
        bready = 1'b1;
      end
      @(posedge clk);
      #1;
      bready = 1'b0;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL b_timeout bvalid never seen");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, bvalid, bid, bresp, fifo_clr, fifo_push, push_data, push_strb,
         push_index, push_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs awready=%b wready=%b bvalid=%b bid=%h bresp=%b clr=%b push=%b data=%h want all 0",
               awready, wready, bvalid, bid, bresp, fifo_clr, fifo_push, push_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({fifo_clr, awready} !== 3'b110) begin
      bad++;
      $display("FAIL init_cycle clr=%b awready=%b want clr=11 awready=0", fifo_clr, awready);
    end
    @(negedge clk);
    total++;
    if ({fifo_clr, awready, bvalid} !== 4'b0010) begin
      bad++;
      $display("FAIL idle_entry clr=%b awready=%b bvalid=%b want clr=00 awready=1 bvalid=0",
               fifo_clr, awready, bvalid);
    end
    idx_model[0] = '0;
    idx_model[1] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc, n0;
    n0 = npush;
    exp_burst(0, 1, 32'hDEADBEEF, 0);
    do_aw(4'd5, 16'h0100, 8'd0, 3'd2);
    send_burst(1, 32'hDEADBEEF, -1, 0, -1, 1, cyc);
    total++;
    if (cyc !== 1) begin bad++; $display("FAIL single_w_latency got=%0d want=1", cyc); end
    wait_b(id, rs, n);
    total++;
    if ({id, rs} !== {4'd5, 2'b00}) begin
      bad++; $display("FAIL single_bresp got id=%0d resp=%b want id=5 resp=00", id, rs);
    end
    total++;
    if (n !== 1) begin bad++; $display("FAIL single_b_latency got=%0d want=1", n); end
    @(negedge clk);
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL single_idle_return awready=%b want=1", awready); end
    @(posedge clk);
    #1;
    total++;
    if (npush - n0 !== 1) begin bad++; $display("FAIL single_push_count got=%0d want=1", npush - n0); end
  endtask

  task automatic test_burst();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc, n0;
    n0 = npush;
    exp_burst(1, 4, 32'h1000_0000, 1);
    do_aw(4'd3, 16'h0400, 8'd3, 3'd2);
    send_burst(4, 32'h1000_0000, -1, 0, -1, 0, cyc);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL burst_cycles got=%0d want=4", cyc); end
    wait_b(id, rs, n);
    total++;
    if ({id, rs} !== {4'd3, 2'b00}) begin
      bad++; $display("FAIL burst_bresp got id=%0d resp=%b want id=3 resp=00", id, rs);
    end
    total++;
    if (npush - n0 !== 4) begin bad++; $display("FAIL burst_push_count got=%0d want=4", npush - n0); end
    // Normal-field write to FIFO1 reveals the incremented index.
    exp_burst(1, 1, 32'h1100_0000, 0);
    do_aw(4'd4, 16'h0300, 8'd0, 3'd2);
    send_burst(1, 32'h1100_0000, -1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
  endtask

  task automatic test_backpressure();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc, n0;
    n0 = npush;
    exp_burst(0, 4, 32'h2000_0000, 0);
    do_aw(4'd6, 16'h0100, 8'd3, 3'd2);
    send_burst(4, 32'h2000_0000, -1, 2, 4, 1, cyc);
    total++;
    if (cyc !== 7) begin bad++; $display("FAIL bp_cycles got=%0d want=7", cyc); end
    wait_b(id, rs, n);
    total++;
    if ({id, rs} !== {4'd6, 2'b00}) begin
      bad++; $display("FAIL bp_bresp got id=%0d resp=%b want id=6 resp=00", id, rs);
    end
    total++;
    if (npush - n0 !== 4) begin bad++; $display("FAIL bp_push_count got=%0d want=4", npush - n0); end
  endtask

  task automatic test_errors();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc, n0;
    // Decode error: window 0x09 is unmapped.
    n0 = npush;
    do_aw(4'd1, 16'h0900, 8'd1, 3'd2);
    send_burst(2, 32'h3000_0000, -1, 0, -1, 1, cyc);
    wait_b(id, rs, n);
    total++;
    if ({id, rs, 32'(npush - n0)} !== {4'd1, 2'b10, 32'd0}) begin
      bad++; $display("FAIL err_decode got id=%0d resp=%b pushes=%0d want id=1 resp=10 pushes=0", id, rs, npush - n0);
    end
    // Size error.
    n0 = npush;
    do_aw(4'd2, 16'h0100, 8'd0, 3'd1);
    send_burst(1, 32'h3100_0000, -1, 0, -1, 1, cyc);
    wait_b(id, rs, n);
    total++;
    if ({id, rs, 32'(npush - n0)} !== {4'd2, 2'b10, 32'd0}) begin
      bad++; $display("FAIL err_size got id=%0d resp=%b pushes=%0d want id=2 resp=10 pushes=0", id, rs, npush - n0);
    end
    // Early wlast on beat 2 of 3: beats still pushed, SLVERR.
    n0 = npush;
    exp_burst(0, 3, 32'h3200_0000, 0);
    do_aw(4'd4, 16'h0100, 8'd2, 3'd2);
    send_burst(3, 32'h3200_0000, 1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
    total++;
    if ({id, rs, 32'(npush - n0)} !== {4'd4, 2'b10, 32'd3}) begin
      bad++; $display("FAIL err_wlast got id=%0d resp=%b pushes=%0d want id=4 resp=10 pushes=3", id, rs, npush - n0);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc;
    for (int i = 0; i < 1024; i++) begin
      exp_burst(0, 1, 32'(i), 1);
      do_aw(4'(i), 16'h0200, 8'd0, 3'd2);
      send_burst(1, 32'(i), -1, 0, -1, 0, cyc);
      wait_b(id, rs, n);
      total++;
      if ({id, rs} !== {4'(i), 2'b00}) begin
        bad++; $display("FAIL wrap_bresp i=%0d got id=%0d resp=%b want id=%0d resp=00", i, id, rs, i % 16);
      end
    end
    // Index is expected back at 0 here.
    exp_burst(0, 1, 32'h4000_0000, 0);
    do_aw(4'd8, 16'h0100, 8'd0, 3'd2);
    send_burst(1, 32'h4000_0000, -1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
  endtask

  task automatic test_clear();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc, n0;
    exp_burst(0, 1, 32'h5000_0000, 1);
    do_aw(4'd9, 16'h0200, 8'd0, 3'd2);
    send_burst(1, 32'h5000_0000, -1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
    n0 = npush;
    clr_cycles = 0;
    clr_or = 2'b00;
    do_aw(4'd7, 16'h0000, 8'd0, 3'd2);
    send_burst(1, 32'h0000_0002, -1, 0, -1, 1, cyc);
    wait_b(id, rs, n);
    idx_model[1] = '0;
    total++;
    if ({id, rs, 32'(npush - n0)} !== {4'd7, 2'b00, 32'd0}) begin
      bad++; $display("FAIL clr_bresp got id=%0d resp=%b pushes=%0d want id=7 resp=00 pushes=0", id, rs, npush - n0);
    end
    total++;
    if ({32'(clr_cycles), clr_or} !== {32'd1, 2'b10}) begin
      bad++; $display("FAIL clr_pulse got cycles=%0d mask=%b want cycles=1 mask=10", clr_cycles, clr_or);
    end
    exp_burst(0, 1, 32'h5100_0000, 0);
    do_aw(4'd10, 16'h0100, 8'd0, 3'd2);
    send_burst(1, 32'h5100_0000, -1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
    exp_burst(1, 1, 32'h5200_0000, 0);
    do_aw(4'd11, 16'h0300, 8'd0, 3'd2);
    send_burst(1, 32'h5200_0000, -1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
  endtask

  task automatic test_midburst_reset();
    logic [3:0] id;
    logic [1:0] rs;
    int n, cyc;
    exp_burst(0, 2, 32'h6000_0000, 0);
    do_aw(4'd12, 16'h0100, 8'd3, 3'd2);
    send_burst(2, 32'h6000_0000, 99, 0, -1, 0, cyc);
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({awready, wready, bvalid, fifo_push, fifo_clr} !== '0) begin
      bad++; $display("FAIL midreset_outputs awready=%b wready=%b bvalid=%b push=%b clr=%b want all 0",
                      awready, wready, bvalid, fifo_push, fifo_clr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idx_model[0] = '0;
    idx_model[1] = '0;
    @(negedge clk);
    total++;
    if ({fifo_clr, bvalid} !== 3'b110) begin
      bad++; $display("FAIL midreset_init got clr=%b bvalid=%b want clr=11 bvalid=0", fifo_clr, bvalid);
    end
    @(posedge clk);
    #1;
    exp_burst(0, 1, 32'h6100_0000, 1);
    do_aw(4'd13, 16'h0200, 8'd0, 3'd2);
    send_burst(1, 32'h6100_0000, -1, 0, -1, 0, cyc);
    wait_b(id, rs, n);
    total++;
    if ({id, rs} !== {4'd13, 2'b00}) begin
      bad++; $display("FAIL midreset_bresp got id=%0d resp=%b want id=13 resp=00", id, rs);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; fifo_full = 2'b00;
    idx_model[0] = '0;
    idx_model[1] = '0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_errors();
    test_wrap();
    test_clear();
    test_midburst_reset();
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_pushes got=%0d outstanding want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
